imem_loader: RTL

Boot-time program loader sitting directly upstream of the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes them sequentially into the instruction memory write port from word 0. It holds the CPU in reset until the image is complete. On success it releases the core via `cpu_run`, whose inverse drives the core's reset.

---
 rtl/imem_loader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time byte-stream loader: assembles big-endian words into instruction memory
// and holds the CPU in reset until the image is complete. Define IMEM_LOADER_CHECKSUM_EN for the trailing XOR checksum byte.
module imem_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              load_err,
   output logic [15:0]       words_loaded
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_WLAST,
      S_CHK,
      S_DONE,
      S_ERR
   } state_e;

   state_e              state_q;
   logic [15:0]         n_q;
   logic [15:0]         wcnt_q;
   logic [1:0]          bcnt_q;
   logic [23:0]         asm_q;
   logic                in_ready_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         wdata_q;
   logic                run_q;
   logic                err_q;
   logic [15:0]         wl_q;

   logic                xfer;
   logic [15:0]         n_d;
   logic [31:0]         word_d;
   logic                last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]          csum_q;
   logic [7:0]          csum_d;
`endif

   always_comb begin
      xfer      = in_valid & in_ready_q;
      n_d       = {n_q[15:8], in_data};
      word_d    = {asm_q, in_data};
      last_word = ((wcnt_q + 16'd1) == n_q);
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d    = csum_q ^ in_data;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         wcnt_q     <= '0;
         bcnt_q     <= '0;
         asm_q      <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         run_q      <= 1'b0;
         err_q      <= 1'b0;
         wl_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         // words_loaded trails the write strobe by one edge; the guard keeps it saturated at N
         if (we_q && (wl_q != n_q)) wl_q <= wl_q + 16'd1;
         case (state_q)
            S_IDLE: begin
               state_q    <= S_HDR_HI;
               in_ready_q <= 1'b1;
            end
            S_HDR_HI: if (xfer) begin
               n_q[15:8] <= in_data;
               state_q   <= S_HDR_LO;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_q    <= csum_d;
`endif
            end
            S_HDR_LO: if (xfer) begin
               n_q <= n_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_q <= csum_d;
`endif
               if ({1'b0, n_d} > 17'(DEPTH)) begin
                  state_q    <= S_ERR;
                  in_ready_q <= 1'b0;
                  err_q      <= 1'b1;
               end else if (n_d == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_q    <= S_CHK;
`else
                  state_q    <= S_DONE;
                  in_ready_q <= 1'b0;
                  run_q      <= 1'b1;
`endif
               end else begin
                  state_q <= S_DATA;
               end
            end
            S_DATA: if (xfer) begin
               asm_q  <= word_d[23:0];
               bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_q <= csum_d;
`endif
               if (bcnt_q == 2'd3) begin
                  we_q    <= 1'b1;
                  addr_q  <= ADDR_W'(wcnt_q);
                  wdata_q <= word_d;
                  wcnt_q  <= wcnt_q + 16'd1;
                  // the final write cycle is a bubble so the run/CHK transition follows the strobe
                  if (last_word) begin
                     state_q    <= S_WLAST;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            S_WLAST: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_q    <= S_CHK;
               in_ready_q <= 1'b1;
`else
               state_q    <= S_DONE;
               run_q      <= 1'b1;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: if (xfer) begin
               in_ready_q <= 1'b0;
               if (in_data == csum_q) begin
                  state_q <= S_DONE;
                  run_q   <= 1'b1;
               end else begin
                  state_q <= S_ERR;
                  err_q   <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_run      = run_q;
   assign load_err     = err_q;
   assign words_loaded = wl_q;

endmodule
